shift_word_tx: RTL and testbench

Parallel-to-serial transmitter that feeds the M0 16-bit shift-register chain. It accepts WIDTH-bit words through a valid/ready handshake and buffers one word in a holding register. Each word is emitted LSB-first, one bit per enabled clock, with first/last-bit markers. Back-to-back words stream with no idle bit as long as the producer refills the holding register before the current word finishes.

---
 rtl/shift_word_tx.sv | 93 +++++++++
 tb/tb_shift_word_tx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_word_tx.sv
// Parallel-to-serial transmitter: one-word holding buffer feeding an LSB-first shifter
// with first/last-bit markers and gapless back-to-back streaming.
module shift_word_tx #(
  parameter int unsigned WIDTH    = 16,
  parameter logic        IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int unsigned CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic [WIDTH-1:0] hold, hold_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             hold_valid, hold_valid_n;
  logic             accept, load;

  // Next-state: accept is en-independent; load/shift only advance on enabled edges.
  always_comb begin
    state_n      = state;
    sh_n         = sh;
    cnt_n        = cnt;
    hold_n       = hold;
    hold_valid_n = hold_valid;

    accept = in_valid && !hold_valid;
    load   = en && hold_valid && ((state == IDLE) || (cnt == LAST));

    if (accept) begin
      hold_n       = in_data;
      hold_valid_n = 1'b1;
    end

    if (load) begin
      sh_n         = hold;
      cnt_n        = '0;
      hold_valid_n = 1'b0;
      state_n      = SHIFT;
    end else if (en && (state == SHIFT)) begin
      if (cnt != LAST) begin
        sh_n  = sh >> 1;
        cnt_n = cnt + CW'(1);
      end else begin
        sh_n    = '0;
        cnt_n   = '0;
        state_n = IDLE;
      end
    end
  end

  // State and registered serial outputs, derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sh         <= '0;
      cnt        <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      ser_out    <= IDLE_BIT;
      ser_first  <= 1'b0;
      ser_last   <= 1'b0;
    end else begin
      state      <= state_n;
      sh         <= sh_n;
      cnt        <= cnt_n;
      hold       <= hold_n;
      hold_valid <= hold_valid_n;
      ser_out    <= (state_n == SHIFT) ? sh_n[0] : IDLE_BIT;
      ser_first  <= (state_n == SHIFT) && (cnt_n == '0);
      ser_last   <= (state_n == SHIFT) && (cnt_n == LAST);
    end
  end

  assign in_ready = !rst && !hold_valid;
  assign busy     = (state == SHIFT) || hold_valid;

endmodule

// File: tb/tb_shift_word_tx.sv
// Bench for shift_word_tx: word-level reference model checked every cycle, plus
// directed scenarios with literal expectations and a randomized soak.
module tb_shift_word_tx;

  localparam int unsigned WIDTH    = 16;
  localparam logic        IDLE_BIT = 1'b0;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready, ser_out, ser_first, ser_last, busy;

  shift_word_tx #(.WIDTH(WIDTH), .IDLE_BIT(IDLE_BIT)) dut (
    .clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ser_out(ser_out), .ser_first(ser_first),
    .ser_last(ser_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the word in flight, which bit of it is showing, and the held word.
  bit               m_active = 0;
  bit               m_hv = 0;
  int               m_idx = 0;
  logic [WIDTH-1:0] m_cur = '0;
  logic [WIDTH-1:0] m_held = '0;

  always @(posedge clk) begin
    bit acc, ld;
    if (rst) begin
      m_active = 0; m_idx = 0; m_hv = 0;
    end else begin
      acc = in_valid && !m_hv;
      ld  = 0;
      if (en) begin
        if (!m_active) ld = m_hv;
        else if (m_idx < WIDTH - 1) m_idx++;
        else if (m_hv) ld = 1;
        else begin m_active = 0; m_idx = 0; end
      end
      if (ld) begin m_cur = m_held; m_idx = 0; m_hv = 0; m_active = 1; end
      if (acc) begin m_held = in_data; m_hv = 1; end
    end
  end

  // Per-cycle compare plus a log of observed outputs for the directed checks.
  bit rec = 0;
  bit q_out[$], q_first[$], q_last[$], q_busy[$];

  always @(negedge clk) begin
    logic e_rdy, e_out, e_first, e_last, e_busy;
    e_rdy   = !rst && !m_hv;
    e_out   = m_active ? m_cur[m_idx] : IDLE_BIT;
    e_first = m_active && (m_idx == 0);
    e_last  = m_active && (m_idx == WIDTH - 1);
    e_busy  = m_active || m_hv;
    n_tests++;
    if ({in_ready, ser_out, ser_first, ser_last, busy} !==
        {e_rdy, e_out, e_first, e_last, e_busy}) begin
      n_fail++;
      $display("FAIL cycle_model t=%0t rdy,out,first,last,busy got %b%b%b%b%b required %b%b%b%b%b",
               $time, in_ready, ser_out, ser_first, ser_last, busy,
               e_rdy, e_out, e_first, e_last, e_busy);
    end
    if (rec) begin
      q_out.push_back(ser_out); q_first.push_back(ser_first);
      q_last.push_back(ser_last); q_busy.push_back(busy);
    end
  end

  // en pattern 1,0,0 repeating while tog is set.
  bit tog = 0;
  int ph = 0;
  always @(posedge clk) begin
    if (tog) begin
      #1;
      ph = (ph == 2) ? 0 : ph + 1;
      en = (ph == 0);
    end
  end

  task automatic chk(input string name, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] w);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) chk("send_timeout", 0, 1);
    in_data  = w;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    q_out.delete(); q_first.delete(); q_last.delete(); q_busy.delete();
  endtask

  function automatic int find_rise(input int from);
    for (int i = (from < 0 ? 0 : from); i < q_first.size(); i++)
      if (q_first[i] && (i == 0 || !q_first[i-1])) return i;
    return -1000;
  endfunction

  function automatic logic [31:0] grab(input int start, input int n, input int step);
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++) begin
      int i = start + k * step;
      if (i >= 0 && i < q_out.size()) v[k] = q_out[i];
      else v[k] = ~v[k];
    end
    return v;
  endfunction

  function automatic int count(input bit which_last);
    int c = 0;
    for (int i = 0; i < q_first.size(); i++) c += which_last ? int'(q_last[i]) : int'(q_first[i]);
    return c;
  endfunction

  function automatic bit log_at(input int i, input int which);
    if (i < 0 || i >= q_out.size()) return 1'bx;
    case (which)
      0: return q_out[i];
      1: return q_first[i];
      2: return q_last[i];
      default: return q_busy[i];
    endcase
  endfunction

  initial begin
    int f1, f2, t, nb;

    // Reset held with a word offered: nothing accepted.
    in_valid = 1'b1; in_data = 16'hBEEF;
    @(negedge clk); chk("reset_ready_low_0", in_ready, 0);
    @(negedge clk); chk("reset_ready_low_1", in_ready, 0);
    @(posedge clk); #1; rst = 1'b0; in_valid = 1'b0; en = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", in_ready, 1);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_out", ser_out, IDLE_BIT);
    chk("post_reset_marks", {ser_first, ser_last}, 0);

    // Single word.
    clear_log(); rec = 1;
    send(16'hA5C3); cycles(20); rec = 0;
    f1 = find_rise(0);
    chk("a5c3_word", grab(f1, 16, 1), 32'h0000A5C3);
    chk("a5c3_first_count", count(0), 1);
    chk("a5c3_last_count", count(1), 1);
    chk("a5c3_last_pos", log_at(f1 + 15, 2), 1);
    chk("a5c3_after_out", log_at(f1 + 16, 0), IDLE_BIT);
    chk("a5c3_after_busy", log_at(f1 + 16, 3), 0);

    // Back-to-back, second word offered as soon as in_ready rises.
    clear_log(); rec = 1;
    send(16'hFFFF); send(16'h0001); cycles(40); rec = 0;
    f1 = find_rise(0); f2 = find_rise(f1 + 1);
    chk("b2b_first_spacing", f2 - f1, 16);
    chk("b2b_stream", grab(f1, 32, 1), 32'h0001FFFF);

    // Late producer: second word offered during the last-bit cycle.
    clear_log(); rec = 1;
    send(16'h00FF);
    t = 0;
    @(negedge clk);
    while (!ser_last && t < 50) begin @(negedge clk); t++; end
    chk("late_wait_last", t < 50, 1);
    in_data = 16'h0F0F; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    cycles(25); rec = 0;
    f1 = find_rise(0); f2 = find_rise(f1 + 1);
    chk("late_gap", f2 - f1, 17);
    chk("late_gap_bit", log_at(f1 + 16, 0), IDLE_BIT);
    chk("late_word1", grab(f1, 16, 1), 32'h000000FF);
    chk("late_word2", grab(f2, 16, 1), 32'h00000F0F);

    // en toggled 1,0,0: each bit held 3 cycles, accept while en=0 not lost.
    clear_log(); rec = 1;
    ph = 2; tog = 1;
    send(16'h8001); send(16'h0003);
    cycles(110); tog = 0; #1; en = 1'b1; rec = 0;
    f1 = find_rise(0); f2 = find_rise(f1 + 1);
    chk("en_word1", grab(f1, 16, 3), 32'h00008001);
    chk("en_hold_first", {log_at(f1 + 1, 1), log_at(f1 + 2, 1), log_at(f1 + 3, 1)}, 3'b110);
    chk("en_word_spacing", f2 - f1, 48);
    chk("en_word2", grab(f2, 16, 3), 32'h00000003);
    chk("en_last_count", count(1), 6);

    // Reset at bit 7 with a second word held: both discarded.
    send(16'h1234); send(16'h5678);
    t = 0;
    @(negedge clk);
    while (!(m_active && m_idx == 7) && t < 60) begin @(negedge clk); t++; end
    chk("rst_wait_bit7", t < 60, 1);
    chk("rst_held_present", busy && !in_ready, 1);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_out", ser_out, IDLE_BIT);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", in_ready, 1);
    nb = 0;
    repeat (40) begin @(negedge clk); nb += int'(busy); end
    chk("rst_no_resume", nb, 0);

    // Randomized soak.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      en       = ($urandom_range(0, 9) < 7);
      in_valid = $urandom_range(0, 1) != 0;
      in_data  = WIDTH'($urandom);
      rst      = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk); #1; rst = 1'b0; in_valid = 1'b0; en = 1'b1;
    cycles(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
